// File: rtl/avalon_word_mem_responder.sv
// Avalon-MM pipelined-read word memory responder with fixed read latency and back-pressure.
// Build option STALL_INJECT_EN adds LFSR-driven pseudo-random waitrequest stalls.
module avalon_word_mem_responder #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_PENDING  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic [3:0]  slave_byteenable
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);
    localparam int unsigned LAT   = READ_LATENCY;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;
    logic              wr_acc;
    logic              rd_acc;
    logic              retire;
    logic              full;
    logic              stall_c;
    logic [CNT_W-1:0]  pending_q;
    logic [CNT_W-1:0]  pending_d;
    logic              vld_q [LAT];
    logic [31:0]       dat_q [LAT];
    logic              unused_addr;

    // Word decode; byte offset and bits above the array wrap silently
    assign word_idx    = slave_address[ADDR_W+1:2];
    assign unused_addr = ^{slave_address[31:ADDR_W+2], slave_address[1:0]};
    assign rd_word     = mem[word_idx];

    // A simultaneous read is dropped in favour of the write
    assign wr_acc = slave_write && !slave_waitrequest;
    assign rd_acc = slave_read && !slave_write && !slave_waitrequest;

    assign retire = vld_q[LAT-1];
    assign full   = (pending_q == CNT_W'(MAX_PENDING));

`ifdef STALL_INJECT_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall_c = (lfsr_q[1:0] == 2'b00);
`else
    assign stall_c = 1'b0;
`endif

    // Retiring response frees a slot in the same cycle, so a full but draining queue still accepts
    assign slave_waitrequest = !rst_n || (full && !retire) || stall_c;

    // Storage is deliberately not reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (slave_byteenable[b]) begin
                    mem[word_idx][8*b +: 8] <= slave_writedata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (rd_acc && !retire) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (!rd_acc && retire) begin
            pending_d = pending_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Read response shift pipeline; data stages only load on a valid entry so the output holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LAT); i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= rd_word;
            end
            for (int i = 1; i < int'(LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign slave_readdatavalid = vld_q[LAT-1];
    assign slave_readdata      = dat_q[LAT-1];

endmodule

// File: doc/avalon_word_mem_responder.md
Name: avalon_word_mem_responder

Overview:
- Avalon-MM slave memory: the responder end of the pipelined-read master protocol that the accelerator blocks use (read/write, waitrequest, readdatavalid).
- Backs 32-bit words in an internal array and returns read data after a fixed, parameterised latency.
- Keeps reads in order, tracks outstanding reads, and applies back-pressure through waitrequest.
- Serves as on-chip scratch memory for accelerators and as the bench memory model for their master ports.

Parameters:
- ADDR_W, 10, word-index bits; array depth is 2**ADDR_W words.
- READ_LATENCY, 2, cycles from read acceptance to readdatavalid; must be >= 1.
- MAX_PENDING, 4, maximum reads accepted but not yet returned; must be >= 1.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- slave_waitrequest  output  1  stall; the command is accepted only in a cycle where this is 0
- slave_address  input  32  byte address
- slave_read  input  1  read request
- slave_readdata  output  32  read data
- slave_readdatavalid  output  1  slave_readdata valid this cycle
- slave_write  input  1  write request
- slave_writedata  input  32  write data
- slave_byteenable  input  4  byte lanes for write; bit i enables bits [8i+7:8i]

Behaviour:
- Reset: one clock, clk; rst_n is asynchronous, active-low.
- Reset values:
  - slave_readdatavalid=0, slave_readdata=0, pending=0, read pipeline cleared.
  - slave_waitrequest=1 while rst_n=0.
  - Memory array is not reset; contents are retained across reset.
- Address decode:
  - word index = slave_address[ADDR_W+1:2].
  - Bits [1:0] and bits above ADDR_W+1 are ignored, so addresses wrap modulo the array size.
- Accept: a command is accepted on a rising edge where (read or write)=1 and waitrequest=0.
- Read and write both asserted: the write is performed and the read is dropped; there is no response and no pending increment.
- Write:
  - Enabled bytes update at the accept edge.
  - No response is generated; single-cycle acceptance.
- Read:
  - Data is sampled from the array at the accept edge and pushed into a READ_LATENCY-deep valid/data shift pipeline.
  - A write accepted on an earlier edge is visible to the read. A write accepted on a later edge does not affect it.
- Response timing:
  - A read accepted in cycle t drives readdatavalid=1 with its data during cycle t+READ_LATENCY for exactly one cycle.
  - Responses come out strictly in acceptance order.
  - slave_readdata holds its last value when valid=0.
- Pending counter:
  - Width is clog2(MAX_PENDING+1).
  - +1 on read accept, -1 on a readdatavalid cycle; both in the same cycle gives no change.
  - It never exceeds MAX_PENDING and never underflows.
- waitrequest (combinational from registers and rst_n):
  - 1 if rst_n=0.
  - Else 1 if pending==MAX_PENDING and no response retires this cycle.
  - Else 0.
  - This retire bypass allows 1 accept per cycle when pending is full but draining.
  - waitrequest does not depend on slave_read or slave_write in the same cycle, so there is no combinational loop.
- Throughput:
  - With MAX_PENDING >= READ_LATENCY: one read per cycle sustained.
  - Otherwise: MAX_PENDING reads per READ_LATENCY cycles.
- Reset mid-operation:
  - All in-flight reads are discarded and no readdatavalid appears after release.
  - Writes accepted before reset persist.

Optional Feature:
- Macro: STALL_INJECT_EN.
- When defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset, advancing every cycle.
  - If LFSR[1:0]==2'b00, waitrequest is forced to 1 that cycle in addition to the normal rule.
  - Responses of already-accepted reads are unaffected.
- When undefined: no LFSR logic exists; waitrequest follows the normal rule only.

Test Plan:
- Write 32'h12345678, byteenable 4'hF, to address 32'h10. Then read 32'h10 (latency 2) -> readdatavalid exactly 2 cycles after accept, readdata=32'h12345678.
- Write 32'hFFFFAAAA with byteenable 4'b0011 to 32'h10 -> a subsequent read returns 32'h1234AAAA. Read address 32'h13 also returns 32'h1234AAAA.
- Preload words 1,2,3,4 at addresses 0,4,8,C; issue 4 back-to-back reads (MAX_PENDING=4, LAT=2) -> waitrequest stays 0; readdatavalid high 4 consecutive cycles with data 1,2,3,4 in order.
- MAX_PENDING=1, LAT=2, read held high continuously -> accepts every 2nd cycle; waitrequest alternates 0,1; pending never exceeds 1.
- Read address 0 accepted in cycle t, write 32'hDEAD to address 0 in cycle t+1 -> read returns the old value; a read issued at t+2 returns 32'hDEAD.
- Issue 2 reads, assert rst_n=0 for 1 cycle before the first response -> readdatavalid never asserts for them. Afterwards a read of an earlier-written address returns the retained data.
